lcd_fb_burst_reader: RTL and testbench

//  Parametrised successor of the single-word LCD framebuffer path.

---
 rtl/lcd_fb_burst_reader.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_fb_burst_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_burst_reader.sv
// Avalon-MM burst read master that streams a framebuffer from SDRAM through a prefetch FIFO
// to a valid/ready pixel port, with a small CSR slave and frame-done interrupt.
module lcd_fb_burst_reader #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned PIX_W      = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_W-1:0]            m0_address,
  output logic                         m0_read,
  output logic [$clog2(MAX_BURST):0]   m0_burstcount,
  input  logic                         m0_waitrequest,
  input  logic                         m0_readdatavalid,
  input  logic [PIX_W-1:0]             m0_readdata,
  input  logic [2:0]                   s0_address,
  input  logic                         s0_read,
  input  logic                         s0_write,
  input  logic [31:0]                  s0_writedata,
  output logic [31:0]                  s0_readdata,
  output logic [PIX_W-1:0]             px_data,
  output logic                         px_valid,
  input  logic                         px_ready,
  output logic                         px_sof,
  output logic                         irq
);

  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StFetch, StDrain, StDone, StAbort} state_e;

  state_e state_q, state_d;

  logic [2:0]        ctrl_q;
  logic              underflow_q, frame_done_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [23:0]       len_q, len_sh_q, rem_q, deliv_q;
  logic [CW-1:0]     out_q, out_d, count_q, credit;
  logic [BW-1:0]     bc_q, bc_next;
  logic              read_q, sof_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PIX_W-1:0]  mem [FIFO_DEPTH];

  logic enable, continuous, irq_en;
  logic accept, flush, push, pop, issue, load, frame_done_set, auto_clear, uf_set;
  logic wr_ctrl, wr_status, wr_base, wr_len;
  logic unused_csr;

  assign enable     = ctrl_q[0];
  assign continuous = ctrl_q[1];
  assign irq_en     = ctrl_q[2];

  assign accept  = read_q & ~m0_waitrequest;
  assign flush   = (state_q == StAbort);
  assign push    = m0_readdatavalid & ~flush;
  assign px_valid = (count_q != '0) & ~flush;
  assign pop     = px_valid & px_ready;
  assign px_data = mem[rd_ptr_q];
  assign px_sof  = px_valid & sof_q;
  assign irq     = frame_done_q & irq_en;

  assign m0_address    = addr_q;
  assign m0_read       = read_q;
  assign m0_burstcount = bc_q;

  // Words in the FIFO plus words in flight never exceed the FIFO depth.
  assign credit  = CW'(FIFO_DEPTH) - count_q - out_q;
  assign bc_next = (rem_q >= 24'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(rem_q);
  assign issue   = (state_q == StFetch) & enable & ~read_q & (rem_q != '0) &
                   (credit >= CW'(bc_next));

  assign uf_set = ((state_q == StFetch) || (state_q == StDrain)) && (count_q == '0) &&
                  (deliv_q < len_sh_q) && px_ready;

  assign wr_ctrl   = s0_write && (s0_address == 3'd0);
  assign wr_status = s0_write && (s0_address == 3'd1);
  assign wr_base   = s0_write && (s0_address == 3'd2);
  assign wr_len    = s0_write && (s0_address == 3'd3);
  assign unused_csr = ^{s0_read, s0_writedata};

  always_comb begin
    out_d = out_q;
    if (accept)           out_d = out_d + CW'(bc_q);
    if (m0_readdatavalid) out_d = out_d - CW'(1);
  end

  always_comb begin
    state_d        = state_q;
    load           = 1'b0;
    frame_done_set = 1'b0;
    auto_clear     = 1'b0;
    unique case (state_q)
      StIdle:  if (enable) state_d = StLoad;
      StLoad: begin
        load = 1'b1;
        if (!enable)            state_d = StAbort;
        else if (len_q == '0)   state_d = StDone;
        else                    state_d = StFetch;
      end
      StFetch: begin
        if (!enable)                          state_d = StAbort;
        else if ((rem_q == '0) && !read_q)    state_d = StDrain;
      end
      StDrain: begin
        if (!enable)                                      state_d = StAbort;
        else if ((out_q == '0) && (deliv_q == len_sh_q))  state_d = StDone;
      end
      StDone: begin
        frame_done_set = 1'b1;
        if (continuous && enable) begin
          state_d = StLoad;
        end else begin
          state_d    = StIdle;
          // One-shot mode: drop enable so the idle state does not restart the frame.
          auto_clear = 1'b1;
        end
      end
      StAbort: if ((out_q == '0) && !read_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
    end else begin
      if (wr_ctrl)         ctrl_q    <= s0_writedata[2:0];
      else if (auto_clear) ctrl_q[0] <= 1'b0;
      underflow_q  <= uf_set | (underflow_q & ~(wr_status & s0_writedata[2]));
      frame_done_q <= frame_done_set | (frame_done_q & ~(wr_status & s0_writedata[1]));
      if (wr_base) base_q <= s0_writedata[ADDR_W-1:0];
      if (wr_len)  len_q  <= s0_writedata[23:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      rem_q    <= '0;
      len_sh_q <= '0;
      deliv_q  <= '0;
      sof_q    <= 1'b0;
      read_q   <= 1'b0;
      bc_q     <= '0;
      out_q    <= '0;
    end else begin
      out_q <= out_d;
      if (load) begin
        addr_q   <= base_q;
        rem_q    <= len_q;
        len_sh_q <= len_q;
        deliv_q  <= '0;
        sof_q    <= 1'b1;
      end else begin
        if (accept) begin
          addr_q <= addr_q + ADDR_W'(bc_q);
          rem_q  <= rem_q - 24'(bc_q);
        end
        if (pop) begin
          deliv_q <= deliv_q + 24'd1;
          sof_q   <= 1'b0;
        end
      end
      if (issue) begin
        read_q <= 1'b1;
        bc_q   <= bc_next;
      end else if (accept) begin
        read_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= m0_readdata;
  end

  always_comb begin
    s0_readdata = '0;
    case (s0_address)
      3'd0: s0_readdata[2:0]        = ctrl_q;
      3'd1: s0_readdata[2:0]        = {underflow_q, frame_done_q, state_q != StIdle};
      3'd2: s0_readdata[ADDR_W-1:0] = base_q;
      3'd3: s0_readdata[23:0]       = len_q;
      3'd4: s0_readdata[CW-1:0]     = count_q;
      default: s0_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_lcd_fb_burst_reader.sv
// Directed self-checking bench for lcd_fb_burst_reader with a behavioural Avalon burst slave.
module tb_lcd_fb_burst_reader;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_address;
  logic          m0_read;
  logic [3:0]    m0_burstcount;
  logic          m0_waitrequest;
  logic          m0_readdatavalid;
  logic [15:0]   m0_readdata;
  logic [2:0]    s0_address;
  logic          s0_read, s0_write;
  logic [31:0]   s0_writedata, s0_readdata;
  logic [15:0]   px_data;
  logic          px_valid, px_ready, px_sof, irq;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] mem_q[$];
  logic [AW-1:0] burst_a[$];
  int            burst_n[$];
  logic [15:0]   pix_q[$];
  bit            sof_q[$];
  int acc_words, rdv_cnt, stab_err, over_err, slow_cnt;
  bit read_seen, valid_seen;
  bit rand_wait, rand_gap, slow, hold_rdv, force_wait;
  logic          pend;
  logic [AW-1:0] pend_a;
  logic [3:0]    pend_n;

  lcd_fb_burst_reader dut (
    .clk              (clk),
    .rst              (rst),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_burstcount    (m0_burstcount),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_readdata      (m0_readdata),
    .s0_address       (s0_address),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_readdata      (s0_readdata),
    .px_data          (px_data),
    .px_valid         (px_valid),
    .px_ready         (px_ready),
    .px_sof           (px_sof),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // Bus/stream monitor: samples pre-edge values at the active edge.
  always @(posedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && (m0_read !== 1'b1 || m0_address !== pend_a || m0_burstcount !== pend_n))
        stab_err++;
      pend   = m0_read && m0_waitrequest;
      pend_a = m0_address;
      pend_n = m0_burstcount;
      if (m0_read) read_seen = 1'b1;
      if (px_valid) valid_seen = 1'b1;
      if (m0_read && !m0_waitrequest) begin
        burst_a.push_back(m0_address);
        burst_n.push_back(int'(m0_burstcount));
        for (int i = 0; i < int'(m0_burstcount); i++) mem_q.push_back(m0_address + AW'(i));
        acc_words += int'(m0_burstcount);
      end
      if (m0_readdatavalid) rdv_cnt++;
      if (px_valid && px_ready) begin
        pix_q.push_back(px_data);
        sof_q.push_back(px_sof);
      end
      if (acc_words - pix_q.size() > 64) over_err++;
    end
  end

  // Memory slave: drives its responses on the inactive edge.
  always @(negedge clk) begin
    slow_cnt++;
    m0_waitrequest = force_wait || (rand_wait && ($urandom_range(0, 1) == 1));
    if (mem_q.size() > 0 && !hold_rdv && !(rand_gap && $urandom_range(0, 2) == 0) &&
        !(slow && (slow_cnt % 4 != 0))) begin
      m0_readdatavalid = 1'b1;
      m0_readdata      = pix_of(mem_q.pop_front());
    end else begin
      m0_readdatavalid = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    burst_a.delete(); burst_n.delete(); pix_q.delete(); sof_q.delete();
    acc_words = 0; rdv_cnt = 0; stab_err = 0; over_err = 0;
    read_seen = 1'b0; valid_seen = 1'b0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s0_address = a; s0_writedata = d; s0_write = 1'b1;
    @(negedge clk);
    s0_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s0_address = a; s0_read = 1'b1;
    #1 d = s0_readdata;
    s0_read = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      csr_read(3'd1, d);
      if (d[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (m0_read !== 1'b0) begin errors++; $display("FAIL reset_m0_read got=%b want=0", m0_read); end
    checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL reset_px_valid got=%b want=0", px_valid); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      csr_read(3'(a), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_csr%0d got=%h want=0", a, d); end
    end
  endtask

  task automatic test_burst();
    logic [31:0] d;
    bit ok;
    int ea[3] = '{32'h100, 32'h108, 32'h110};
    int en[3] = '{8, 8, 4};
    int bad = 0;
    clear_log();
    px_ready = 1'b1;
    csr_write(3'd2, 32'h100);
    csr_write(3'd3, 32'd20);
    csr_write(3'd0, 32'h1);
    wait_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_idle got=busy want=idle"); end
    checks++; if (burst_a.size() != 3) begin errors++; $display("FAIL t1_nbursts got=%0d want=3", burst_a.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (int'(burst_a[i]) != ea[i] || burst_n[i] != en[i]) begin
        errors++;
        $display("FAIL t1_burst%0d got=(%h,%0d) want=(%h,%0d)", i, burst_a[i], burst_n[i], ea[i], en[i]);
      end
    end
    checks++; if (pix_q.size() != 20) begin errors++; $display("FAIL t1_npix got=%0d want=20", pix_q.size()); end
    for (int i = 0; i < pix_q.size(); i++) if (pix_q[i] !== pix_of(AW'(32'h100 + i))) bad++;
    for (int i = 1; i < sof_q.size(); i++) if (sof_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL t1_data_sof got=%0d bad want=0", bad); end
    checks++; if (sof_q[0] !== 1'b1) begin errors++; $display("FAIL t1_sof0 got=%b want=1", sof_q[0]); end
    csr_read(3'd1, d);
    checks++; if (d[1:0] !== 2'b10) begin errors++; $display("FAIL t1_status got=%b want=10", d[1:0]); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t1_irq_off got=%b want=0", irq); end
    csr_write(3'd0, 32'h4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t1_irq_on got=%b want=1", irq); end
    csr_write(3'd0, 32'h0);
    csr_write(3'd1, 32'h6);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    bit ok;
    int bad = 0;
    clear_log();
    px_ready = 1'b0;
    csr_write(3'd2, 32'h1000);
    csr_write(3'd3, 32'd200);
    csr_write(3'd0, 32'h1);
    repeat (200) @(negedge clk);
    checks++; if (acc_words != 64) begin errors++; $display("FAIL t2_issued got=%0d want=64", acc_words); end
    csr_read(3'd4, d);
    checks++; if (d !== 32'd64) begin errors++; $display("FAIL t2_level got=%0d want=64", d); end
    px_ready = 1'b1;
    repeat (7) @(negedge clk);
    px_ready = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (acc_words != 64) begin errors++; $display("FAIL t2_credit7 got=%0d want=64", acc_words); end
    px_ready = 1'b1;
    @(negedge clk);
    px_ready = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (acc_words != 72) begin errors++; $display("FAIL t2_credit8 got=%0d want=72", acc_words); end
    for (int i = 0; i < 8; i++) if (pix_q[i] !== pix_of(AW'(32'h1000 + i))) bad++;
    checks++; if (bad != 0 || pix_q.size() != 8) begin errors++; $display("FAIL t2_pixels got=%0d bad/%0d want=0/8", bad, pix_q.size()); end
    checks++; if (over_err != 0) begin errors++; $display("FAIL t2_overcommit got=%0d want=0", over_err); end
    csr_write(3'd0, 32'h0);
    wait_idle(200, ok);
    csr_read(3'd4, d);
    checks++; if (!ok || d !== 32'd0) begin errors++; $display("FAIL t2_abort got=ok%0d level%0d want=ok1 level0", ok, d); end
    csr_write(3'd1, 32'h6);
  endtask

  task automatic test_continuous();
    bit ok;
    int bad = 0, sbad = 0;
    logic [AW-1:0] ea;
    clear_log();
    rand_wait = 1'b1; rand_gap = 1'b1; px_ready = 1'b1;
    csr_write(3'd2, 32'h200);
    csr_write(3'd3, 32'd37);
    csr_write(3'd0, 32'h3);
    for (int i = 0; i < 2000 && pix_q.size() < 10; i++) @(negedge clk);
    checks++; if (pix_q.size() < 10) begin errors++; $display("FAIL t3_start got=%0d want>=10", pix_q.size()); end
    csr_write(3'd2, 32'h300);
    for (int i = 0; i < 4000 && pix_q.size() < 80; i++) @(negedge clk);
    checks++; if (pix_q.size() < 80) begin errors++; $display("FAIL t3_frame3 got=%0d want>=80", pix_q.size()); end
    csr_write(3'd0, 32'h1);
    wait_idle(3000, ok);
    rand_wait = 1'b0; rand_gap = 1'b0;
    checks++; if (!ok || pix_q.size() != 111) begin errors++; $display("FAIL t3_npix got=%0d want=111", pix_q.size()); end
    for (int i = 0; i < pix_q.size(); i++) begin
      ea = AW'(((i / 37) == 0 ? 32'h200 : 32'h300) + (i % 37));
      if (pix_q[i] !== pix_of(ea)) bad++;
      if (sof_q[i] !== ((i % 37) == 0)) sbad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL t3_data got=%0d bad want=0", bad); end
    checks++; if (sbad != 0) begin errors++; $display("FAIL t3_sof got=%0d bad want=0", sbad); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL t3_hold got=%0d changes want=0", stab_err); end
    checks++; if (acc_words != 111) begin errors++; $display("FAIL t3_words got=%0d want=111", acc_words); end
    csr_write(3'd1, 32'h6);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    bit ok;
    clear_log();
    hold_rdv = 1'b1; px_ready = 1'b0;
    csr_write(3'd2, 32'h500);
    csr_write(3'd3, 32'd16);
    csr_write(3'd0, 32'h1);
    for (int i = 0; i < 100 && acc_words < 16; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++; if (acc_words != 16) begin errors++; $display("FAIL t4_issued got=%0d want=16", acc_words); end
    csr_write(3'd0, 32'h0);
    csr_read(3'd1, d);
    checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL t4_busy_held got=%b want=1", d[0]); end
    hold_rdv = 1'b0;
    for (int i = 0; i < 100 && mem_q.size() > 0; i++) @(negedge clk);
    wait_idle(20, ok);
    csr_read(3'd4, d);
    checks++; if (!ok) begin errors++; $display("FAIL t4_busy_drop got=busy want=idle"); end
    checks++; if (rdv_cnt != 16) begin errors++; $display("FAIL t4_absorbed got=%0d want=16", rdv_cnt); end
    checks++; if (valid_seen) begin errors++; $display("FAIL t4_px_valid got=1 want=0"); end
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL t4_level got=%0d want=0", d); end
    csr_write(3'd1, 32'h6);
  endtask

  task automatic test_len_zero();
    logic [31:0] d;
    bit ok;
    clear_log();
    csr_write(3'd3, 32'd0);
    csr_write(3'd0, 32'h5);
    wait_idle(50, ok);
    csr_read(3'd1, d);
    checks++; if (!ok || read_seen) begin errors++; $display("FAIL t5_no_read got=%0d want=0", read_seen); end
    checks++; if (d[1] !== 1'b1) begin errors++; $display("FAIL t5_done got=%b want=1", d[1]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t5_irq got=%b want=1", irq); end
    csr_write(3'd1, 32'h2);
    csr_read(3'd1, d);
    checks++; if (d[1] !== 1'b0) begin errors++; $display("FAIL t5_w1c got=%b want=0", d[1]); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t5_irq_clr got=%b want=0", irq); end
    csr_write(3'd0, 32'h0);
  endtask

  task automatic test_underflow_reset();
    logic [31:0] d;
    bit ok;
    int bad = 0;
    clear_log();
    slow = 1'b1; px_ready = 1'b1;
    csr_write(3'd2, 32'h40);
    csr_write(3'd3, 32'd12);
    csr_write(3'd0, 32'h1);
    wait_idle(1000, ok);
    slow = 1'b0;
    csr_read(3'd1, d);
    checks++; if (!ok || d[2] !== 1'b1) begin errors++; $display("FAIL t6_underflow got=%b want=1", d[2]); end
    for (int i = 0; i < pix_q.size(); i++) if (pix_q[i] !== pix_of(AW'(32'h40 + i))) bad++;
    checks++; if (bad != 0 || pix_q.size() != 12) begin errors++; $display("FAIL t6_order got=%0d bad/%0d want=0/12", bad, pix_q.size()); end
    clear_log();
    force_wait = 1'b1;
    csr_write(3'd3, 32'd64);
    csr_write(3'd0, 32'h5);
    for (int i = 0; i < 50 && !read_seen; i++) @(negedge clk);
    @(negedge clk);
    checks++; if (m0_read !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL t6_pending got=%b%b want=11", m0_read, irq); end
    s0_address = 3'd1;
    rst = 1'b1;
    #1;
    checks++; if (m0_read !== 1'b0) begin errors++; $display("FAIL t6_rst_read got=%b want=0", m0_read); end
    checks++; if (px_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL t6_rst_px_irq got=%b%b want=00", px_valid, irq); end
    checks++; if (s0_readdata !== 32'h0) begin errors++; $display("FAIL t6_rst_status got=%h want=0", s0_readdata); end
    repeat (2) @(negedge clk);
    force_wait = 1'b0;
    mem_q.delete();
    @(negedge clk);
    rst = 1'b0;
    csr_read(3'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t6_rst_ctrl got=%h want=0", d); end
  endtask

  initial begin
    rst = 1'b1;
    m0_waitrequest = 1'b0; m0_readdatavalid = 1'b0; m0_readdata = '0;
    s0_address = '0; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = '0;
    px_ready = 1'b0;
    rand_wait = 1'b0; rand_gap = 1'b0; slow = 1'b0; hold_rdv = 1'b0; force_wait = 1'b0;
    slow_cnt = 0; pend = 1'b0;
    clear_log();
    test_reset();
    test_burst();
    test_backpressure();
    test_continuous();
    test_abort();
    test_len_zero();
    test_underflow_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
